// File: rtl/ram_stream_pkg.sv
// Shared types and constants for the RAM stream reader and its output buffer.
package ram_stream_pkg;

  localparam int FIFO_DEPTH = 4;
  localparam int CNT_W      = 3;
  localparam int PTR_W      = 2;
  localparam logic [CNT_W-1:0] FIFO_DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/ram_stream_fifo.sv
// 4-entry synchronous FIFO with flush and occupancy count; push when full
// and pop when empty are ignored.
module ram_stream_fifo
  import ram_stream_pkg::*;
#(
  parameter int DW = 18
) (
  input  logic             clk,
  input  logic             res_n,
  input  logic             flush,
  input  logic             push,
  input  logic [DW-1:0]    wdata,
  input  logic             pop,
  output logic [DW-1:0]    rdata,
  output logic [CNT_W-1:0] count
);

  logic [DW-1:0]    mem_q [FIFO_DEPTH];
  logic [DW-1:0]    mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  always_comb begin
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    do_push = push && (cnt_q != FIFO_DEPTH_C);
    do_pop  = pop && (cnt_q != '0);
    if (do_push) begin
      mem_d[wr_q] = wdata;
      wr_d        = wr_q + 1'b1;
    end
    if (do_pop) begin
      rd_d = rd_q + 1'b1;
    end
    cnt_d = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
    if (flush) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  assign rdata = mem_q[rd_q];
  assign count = cnt_q;

endmodule

// File: rtl/ram_stream_reader.sv
// Burst reader: streams 'length' RAM words from start_addr out through a
// valid/ready port. Optional abort input enabled by RAM_STREAM_READER_ABORT_EN.
module ram_stream_reader
  import ram_stream_pkg::*;
#(
  parameter int DATASIZE  = 18,
  parameter int ADDRSIZE  = 8,
  parameter int PIPELINED = 0
) (
  input  logic                clk,
  input  logic                res_n,
  input  logic                start,
  input  logic [ADDRSIZE-1:0] start_addr,
  input  logic [ADDRSIZE:0]   length,
  output logic                busy,
  output logic                done,
  output logic                ram_ren,
  output logic [ADDRSIZE-1:0] ram_addr,
  input  logic [DATASIZE-1:0] ram_rdata,
  output logic                out_valid,
  output logic [DATASIZE-1:0] out_data,
  input  logic                out_ready,
`ifdef RAM_STREAM_READER_ABORT_EN
  input  logic                abort,
`endif
  output state_t              dbg_state
);

  // Stream handshake: a word transfers in any cycle with out_valid && out_ready;
  // while out_valid=1 and out_ready=0 the word and out_data are held unchanged.

  localparam int LAT = 1 + PIPELINED;

  state_t              state_q, state_d;
  logic [ADDRSIZE-1:0] addr_q, addr_d;
  logic [ADDRSIZE:0]   rem_q, rem_d;
  logic [LAT-1:0]      infl_q, infl_d;
  logic                done_q, done_d;
  logic [CNT_W-1:0]    infl_cnt, fifo_cnt, occ;
  logic [DATASIZE-1:0] fifo_rdata;
  logic                fifo_empty, capture, push, pop, hs, kill;

`ifdef RAM_STREAM_READER_ABORT_EN
  assign kill = abort && (state_q != IDLE);
`else
  assign kill = 1'b0;
`endif

  always_comb begin
    infl_cnt = '0;
    for (int i = 0; i < LAT; i++) infl_cnt = infl_cnt + CNT_W'(infl_q[i]);
  end

  assign occ        = fifo_cnt + infl_cnt;
  assign capture    = infl_q[LAT-1];
  assign fifo_empty = (fifo_cnt == '0);

  // Credit check keeps buffered plus outstanding words within the FIFO depth.
  assign ram_ren = (state_q == READ) && (occ < FIFO_DEPTH_C) && !kill;

  // An arriving word bypasses the empty FIFO when it can hand off immediately.
  assign out_valid = !fifo_empty || capture;
  assign out_data  = !fifo_empty ? fifo_rdata : (capture ? ram_rdata : '0);
  assign hs        = out_valid && out_ready;
  assign push      = capture && !(fifo_empty && out_ready) && !kill;
  assign pop       = !fifo_empty && out_ready;

  always_comb begin
    infl_d[0] = ram_ren;
    for (int i = 1; i < LAT; i++) infl_d[i] = infl_q[i-1];
    if (kill) infl_d = '0;
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (length != '0) begin
            state_d = READ;
            addr_d  = start_addr;
            rem_d   = length;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      READ: begin
        if (ram_ren) begin
          addr_d = addr_q + 1'b1;
          rem_d  = rem_q - 1'b1;
          if (rem_q == 1) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (hs && (occ == CNT_W'(1))) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (kill) begin
      state_d = IDLE;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      infl_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      infl_q  <= infl_d;
      done_q  <= done_d;
    end
  end

  ram_stream_fifo #(.DW(DATASIZE)) u_fifo (
    .clk   (clk),
    .res_n (res_n),
    .flush (kill),
    .push  (push),
    .wdata (ram_rdata),
    .pop   (pop),
    .rdata (fifo_rdata),
    .count (fifo_cnt)
  );

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign ram_addr  = addr_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_ram_stream_reader.sv
// Bench for ram_stream_reader: one instance with 1-cycle RAM and one with
// 2-cycle RAM, driven by the same directed sequence and checked against a word queue.
module tb_ram_stream_reader;
  import ram_stream_pkg::*;

  localparam int DW = 18;
  localparam int AW = 8;

  logic                clk;
  logic                res_n;
  logic                start;
  logic [AW-1:0]       start_addr;
  logic [AW:0]         length;
  logic                out_ready;
  logic                abort;
  logic [1:0]          busy_v, done_v, ren_v, valid_v;
  logic [1:0][AW-1:0]  addr_v;
  logic [1:0][DW-1:0]  rdata_v, data_v;
  logic [DW-1:0]       stage1;
  state_t              dbg0, dbg1;

  logic [DW-1:0] mem [256];
  logic [DW-1:0] exp_q0[$];
  logic [DW-1:0] exp_q1[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int ren_cnt[2], hs_cnt[2], done_cnt[2];
  int first_ren[2], last_ren[2], first_v[2], last_hs[2], done_cyc[2];
  int base_ren[2], base_done[2];
  logic [AW-1:0] exp_addr[2];
  logic [1:0]    stall_q;
  logic [DW-1:0] hold_d[2];

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ram_stream_reader #(.DATASIZE(DW), .ADDRSIZE(AW), .PIPELINED(0)) u_dut0 (
    .clk(clk), .res_n(res_n), .start(start), .start_addr(start_addr), .length(length),
    .busy(busy_v[0]), .done(done_v[0]), .ram_ren(ren_v[0]), .ram_addr(addr_v[0]),
    .ram_rdata(rdata_v[0]), .out_valid(valid_v[0]), .out_data(data_v[0]),
    .out_ready(out_ready),
`ifdef RAM_STREAM_READER_ABORT_EN
    .abort(abort),
`endif
    .dbg_state(dbg0)
  );

  ram_stream_reader #(.DATASIZE(DW), .ADDRSIZE(AW), .PIPELINED(1)) u_dut1 (
    .clk(clk), .res_n(res_n), .start(start), .start_addr(start_addr), .length(length),
    .busy(busy_v[1]), .done(done_v[1]), .ram_ren(ren_v[1]), .ram_addr(addr_v[1]),
    .ram_rdata(rdata_v[1]), .out_valid(valid_v[1]), .out_data(data_v[1]),
    .out_ready(out_ready),
`ifdef RAM_STREAM_READER_ABORT_EN
    .abort(abort),
`endif
    .dbg_state(dbg1)
  );

  // RAM models: latency 1 and latency 2
  always @(posedge clk) begin
    if (ren_v[0]) rdata_v[0] <= mem[addr_v[0]];
    if (ren_v[1]) stage1 <= mem[addr_v[1]];
    rdata_v[1] <= stage1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_size(input int k);
    return (k == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  // scoreboard / monitor for one instance, sampled on the falling edge
  task automatic mon(input int k);
    logic [DW-1:0] e;
    if (ren_v[k]) begin
      check($sformatf("ram_addr%0d", k), 32'(addr_v[k]), 32'(exp_addr[k]));
      exp_addr[k] = exp_addr[k] + 8'd1;
      if (first_ren[k] < 0) first_ren[k] = cyc;
      last_ren[k] = cyc;
      ren_cnt[k]++;
    end
    if (stall_q[k]) begin
      check($sformatf("hold_valid%0d", k), 32'(valid_v[k]), 32'd1);
      check($sformatf("hold_data%0d", k), 32'(data_v[k]), 32'(hold_d[k]));
    end
    if (valid_v[k] && first_v[k] < 0) first_v[k] = cyc;
    if (valid_v[k] && out_ready) begin
      check($sformatf("word_expected%0d", k), 32'(exp_size(k) != 0), 32'd1);
      if (exp_size(k) != 0) begin
        e = (k == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
        check($sformatf("out_data%0d", k), 32'(data_v[k]), 32'(e));
      end
      hs_cnt[k]++;
      last_hs[k] = cyc;
    end
    stall_q[k] = valid_v[k] && !out_ready;
    hold_d[k]  = data_v[k];
    if (done_v[k]) begin
      done_cnt[k]++;
      done_cyc[k] = cyc;
      check($sformatf("busy_at_done%0d", k), 32'(busy_v[k]), 32'd0);
    end
  endtask

  always @(negedge clk) begin
    if (res_n) begin
      mon(0);
      mon(1);
    end else begin
      stall_q = '0;
    end
  end

  // driver tasks
  task automatic do_start(input logic [AW-1:0] a, input logic [AW:0] l);
    logic [AW-1:0] ad;
    @(posedge clk); #1;
    for (int k = 0; k < 2; k++) begin
      exp_addr[k]  = a;
      first_ren[k] = -1;
      first_v[k]   = -1;
      base_ren[k]  = ren_cnt[k];
      base_done[k] = done_cnt[k];
    end
    for (int i = 0; i < int'(l); i++) begin
      ad = a + AW'(i);
      exp_q0.push_back(mem[ad]);
      exp_q1.push_back(mem[ad]);
    end
    start = 1'b1; start_addr = a; length = l;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int len, input int max, input logic rnd_ready);
    for (int i = 0; i < max; i++) begin
      @(posedge clk); #1;
      if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
      if (done_cnt[0] > base_done[0] && done_cnt[1] > base_done[1]) break;
    end
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("done_count%0d", k), 32'(done_cnt[k] - base_done[k]), 32'd1);
      check($sformatf("reads_issued%0d", k), 32'(ren_cnt[k] - base_ren[k]), 32'(len));
      check($sformatf("queue_drained%0d", k), 32'(exp_size(k)), 32'd0);
      check($sformatf("done_after_hs%0d", k), 32'(done_cyc[k] - last_hs[k]), 32'd1);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("%s_busy%0d", tag, k), 32'(busy_v[k]), 32'd0);
      check($sformatf("%s_done%0d", tag, k), 32'(done_v[k]), 32'd0);
      check($sformatf("%s_ren%0d", tag, k), 32'(ren_v[k]), 32'd0);
      check($sformatf("%s_addr%0d", tag, k), 32'(addr_v[k]), 32'd0);
      check($sformatf("%s_valid%0d", tag, k), 32'(valid_v[k]), 32'd0);
      check($sformatf("%s_data%0d", tag, k), 32'(data_v[k]), 32'd0);
    end
  endtask

  initial begin
    int b0, b1;
    for (int i = 0; i < 256; i++) mem[i] = DW'($urandom_range(1, 262143));
    for (int k = 0; k < 2; k++) begin
      ren_cnt[k] = 0; hs_cnt[k] = 0; done_cnt[k] = 0;
      first_ren[k] = -1; first_v[k] = -1; last_ren[k] = 0; last_hs[k] = 0; done_cyc[k] = 0;
      exp_addr[k] = '0; hold_d[k] = '0;
    end
    stall_q = '0;
    stage1 = '0;
    rdata_v = '0;
    res_n = 1'b1; start = 1'b0; start_addr = '0; length = '0; out_ready = 1'b1; abort = 1'b0;
    #2 res_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1 res_n = 1'b1;

    // basic burst, consecutive addresses
    do_start(8'h10, 9'd4);
    wait_done(4, 100, 1'b0);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("t1_latency%0d", k), 32'(first_v[k] - first_ren[k]), 32'(1 + k));
      check($sformatf("t1_back_to_back%0d", k), 32'(last_ren[k] - first_ren[k]), 32'd3);
    end

    // address wrap
    do_start(8'hFE, 9'd3);
    wait_done(3, 100, 1'b0);
    for (int k = 0; k < 2; k++)
      check($sformatf("t2_latency%0d", k), 32'(first_v[k] - first_ren[k]), 32'(1 + k));

    // backpressure: reads stop at FIFO depth
    out_ready = 1'b0;
    do_start(8'h40, 9'd16);
    repeat (10) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("t3_reads_stalled%0d", k), 32'(ren_cnt[k] - base_ren[k]), 32'd4);
      check($sformatf("t3_valid%0d", k), 32'(valid_v[k]), 32'd1);
      check($sformatf("t3_head%0d", k), 32'(data_v[k]), 32'(mem[8'h40]));
    end
    out_ready = 1'b1;
    wait_done(16, 200, 1'b0);

    // zero length
    b0 = ren_cnt[0]; b1 = ren_cnt[1];
    base_done[0] = done_cnt[0]; base_done[1] = done_cnt[1];
    @(posedge clk); #1;
    start = 1'b1; start_addr = 8'h33; length = '0;
    @(negedge clk);
    check("t4_no_early_done", 32'(done_v), 32'd0);
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    check("t4_done_pulse", 32'(done_v), 32'd3);
    check("t4_busy", 32'(busy_v), 32'd0);
    @(negedge clk);
    check("t4_done_single", 32'(done_v), 32'd0);
    repeat (3) @(negedge clk);
    check("t4_no_reads0", 32'(ren_cnt[0] - b0), 32'd0);
    check("t4_no_reads1", 32'(ren_cnt[1] - b1), 32'd0);
    check("t4_done_cnt0", 32'(done_cnt[0] - base_done[0]), 32'd1);

    // start pulsed mid-burst is ignored
    do_start(8'h80, 9'd6);
    @(posedge clk); #1;
    start = 1'b1; start_addr = 8'h00; length = 9'd5;
    @(posedge clk); #1 start = 1'b0;
    wait_done(6, 100, 1'b0);

    // random backpressure
    do_start(8'h90, 9'd12);
    wait_done(12, 400, 1'b1);

    // reset after the 2nd word of an 8-word burst
    do_start(8'h20, 9'd8);
    b0 = hs_cnt[0] - (8 - exp_q0.size());
    for (int i = 0; i < 50; i++) begin
      if (hs_cnt[0] - b0 >= 2) break;
      @(posedge clk); #1;
    end
    check("t6_two_words_seen", 32'(hs_cnt[0] - b0), 32'd2);
    res_n = 1'b0;
    exp_q0.delete(); exp_q1.delete();
    @(negedge clk);
    check_reset_outputs("midreset");
    b0 = done_cnt[0]; b1 = done_cnt[1];
    @(posedge clk); #1 res_n = 1'b1;
    repeat (6) @(negedge clk);
    check("t6_no_done0", 32'(done_cnt[0] - b0), 32'd0);
    check("t6_no_done1", 32'(done_cnt[1] - b1), 32'd0);
    do_start(8'h30, 9'd2);
    wait_done(2, 100, 1'b0);

`ifdef RAM_STREAM_READER_ABORT_EN
    // abort while word 3 is presented
    do_start(8'h50, 9'd8);
    b0 = hs_cnt[0];
    for (int i = 0; i < 50; i++) begin
      if (hs_cnt[0] - b0 >= 2) break;
      @(posedge clk); #1;
    end
    abort = 1'b1;
    @(negedge clk);
    check("t7_ren_off", 32'(ren_v), 32'd0);
    @(posedge clk); #1;
    abort = 1'b0;
    exp_q0.delete(); exp_q1.delete();
    b0 = done_cnt[0]; b1 = done_cnt[1];
    @(negedge clk);
    check("t7_idle0", 32'(dbg0), 32'(IDLE));
    check("t7_idle1", 32'(dbg1), 32'(IDLE));
    check("t7_valid_off", 32'(valid_v), 32'd0);
    repeat (5) @(negedge clk);
    check("t7_no_done0", 32'(done_cnt[0] - b0), 32'd0);
    check("t7_no_done1", 32'(done_cnt[1] - b1), 32'd0);
    do_start(8'h60, 9'd3);
    wait_done(3, 100, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
